// File: rtl/picorv32_bus_pkg.sv
// Shared types and constants for the two-master PicoRV32 native-bus arbiter.
package picorv32_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_req_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating watchdog counter; flags the last allowed cycle of a stalled grant.
module bus_timeout_ctr
    import picorv32_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic hit_c
);

    localparam logic [CNT_W-1:0] HIT_VAL = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    // en already excludes s_ready, so a coincident slave completion wins
    assign hit_c = (TIMEOUT != 0) && (count == HIT_VAL) && en;

endmodule

// File: rtl/picorv32_bus_arbiter.sv
// Round-robin arbiter: two PicoRV32 native-bus masters onto one slave port, with watchdog.
module picorv32_bus_arbiter
    import picorv32_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT      = 16,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready
);

    state_t   state, next_state;
    logic     last_grant, next_last_grant;
    logic     timeout_hit;
    logic     done;
    bus_req_t m0_req, m1_req, s_req;

    assign m0_req = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (resetn),
        .clear (state == IDLE),
        .en    ((state != IDLE) && !s_ready),
        .hit_c (timeout_hit)
    );

    assign done = s_ready || timeout_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    // Grant selection and slave/master muxing; everything is idle-zero by default
    always_comb begin
        next_state      = state;
        next_last_grant = last_grant;
        s_valid         = 1'b0;
        s_req           = '0;
        m0_ready        = 1'b0;
        m1_ready        = 1'b0;
        m0_rdata        = '0;
        m1_rdata        = '0;

        case (state)
            IDLE: begin
                if (m0_valid && (!m1_valid || last_grant)) begin
                    next_state      = GRANT0;
                    next_last_grant = 1'b0;
                end else if (m1_valid) begin
                    next_state      = GRANT1;
                    next_last_grant = 1'b1;
                end
            end
            GRANT0: begin
                s_valid  = 1'b1;
                s_req    = m0_req;
                m0_ready = done;
                m0_rdata = timeout_hit ? TIMEOUT_DATA : s_rdata;
                if (done) next_state = IDLE;
            end
            GRANT1: begin
                s_valid  = 1'b1;
                s_req    = m1_req;
                m1_ready = done;
                m1_rdata = timeout_hit ? TIMEOUT_DATA : s_rdata;
                if (done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign s_addr  = s_req.addr;
    assign s_wdata = s_req.wdata;
    assign s_wstrb = s_req.wstrb;

endmodule

// File: tb/tb_picorv32_bus_arbiter.sv
// Directed self-checking bench for picorv32_bus_arbiter.
module tb_picorv32_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;

    int n_checks = 0;
    int n_errors = 0;

    picorv32_bus_arbiter #(
        .TIMEOUT      (16),
        .TIMEOUT_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_rdata (m0_rdata),
        .m0_ready (m0_ready),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_rdata (m1_rdata),
        .m1_ready (m1_ready),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_rdata  = '0;   s_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    int n_rec;
    logic [31:0] rec [8];

    initial begin
        // 1: reset values, then a simple m0 read
        do_reset();
        resetn = 1'b0;
        #1;
        check("rst_s_valid",  32'(s_valid),  32'd0);
        check("rst_m0_ready", 32'(m0_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_ready), 32'd0);
        check("rst_s_addr",   s_addr,        32'd0);
        check("rst_m0_rdata", m0_rdata,      32'd0);
        resetn = 1'b1;
        tick();

        m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'b0000;
        s_rdata  = 32'h1234_5678;
        #1;
        check("t1_idle_s_valid", 32'(s_valid), 32'd0);
        tick();
        check("t1_s_valid",  32'(s_valid),  32'd1);
        check("t1_s_addr",   s_addr,        32'h0000_0100);
        check("t1_wait_rdy", 32'(m0_ready), 32'd0);
        tick();
        s_ready = 1'b1;
        #1;
        check("t1_m0_ready", 32'(m0_ready), 32'd1);
        check("t1_m0_rdata", m0_rdata,      32'h1234_5678);
        check("t1_m1_ready", 32'(m1_ready), 32'd0);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        check("t1_ready_pulse", 32'(m0_ready), 32'd0);
        check("t1_back_idle",   32'(s_valid),  32'd0);

        // 2: simultaneous requests after reset alternate 0,1,0,1 with one IDLE cycle between
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0010;
        m1_valid = 1'b1; m1_addr = 32'h0000_0020;
        s_ready  = 1'b1;
        n_rec = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (m0_ready && n_rec < 8) begin rec[n_rec] = 32'(cyc); n_rec++; end
            if (m1_ready && n_rec < 8) begin rec[n_rec] = 32'h100 | 32'(cyc); n_rec++; end
            if (n_rec == 8) break;
            tick();
        end
        check("t2_grant_count", 32'(n_rec), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_grant%0d", i), rec[i], (32'(i % 2) << 8) | 32'(2 * i + 1));
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick();
        s_ready = 1'b0;
        tick();

        // 3: m1 write presented unchanged on the slave port
        m1_valid = 1'b1; m1_addr = 32'h2000_0000; m1_wdata = 32'h0000_00A5; m1_wstrb = 4'b0001;
        s_rdata  = 32'h5555_AAAA;
        tick();
        check("t3_s_valid",  32'(s_valid),  32'd1);
        check("t3_s_addr",   s_addr,        32'h2000_0000);
        check("t3_s_wdata",  s_wdata,       32'h0000_00A5);
        check("t3_s_wstrb",  32'(s_wstrb),  32'h1);
        check("t3_m0_rdata", m0_rdata,      32'd0);
        check("t3_wait_rdy", 32'(m1_ready), 32'd0);
        tick();
        s_ready = 1'b1;
        #1;
        check("t3_m1_ready", 32'(m1_ready), 32'd1);
        check("t3_m0_ready", 32'(m0_ready), 32'd0);
        tick();
        m1_valid = 1'b0; s_ready = 1'b0;
        #1;
        check("t3_ready_pulse", 32'(m1_ready), 32'd0);

        // 4: slave never answers -> forced completion on the 16th grant cycle
        m0_valid = 1'b1; m0_addr = 32'h0000_0300; s_rdata = 32'h0BAD_F00D;
        tick();
        for (int k = 1; k <= 16; k++) begin
            #1;
            check($sformatf("t4_ready_c%0d", k), 32'(m0_ready), 32'(k == 16));
            if (k == 16) begin
                check("t4_rdata", m0_rdata, 32'hDEAD_BEEF);
                m0_valid = 1'b0;
            end
            tick();
        end
        check("t4_idle", 32'(s_valid), 32'd0);

        // 5: slave ready coincident with the timeout cycle returns real data
        m0_valid = 1'b1; s_rdata = 32'h600D_CAFE;
        tick();
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) s_ready = 1'b1;
            #1;
            if (k == 15) check("t5_ready_c15", 32'(m0_ready), 32'd0);
            if (k == 16) begin
                check("t5_ready_c16", 32'(m0_ready), 32'd1);
                check("t5_rdata",     m0_rdata,      32'h600D_CAFE);
                m0_valid = 1'b0;
            end
            tick();
        end
        s_ready = 1'b0;
        #1;
        check("t5_idle", 32'(s_valid), 32'd0);

        // 6: asynchronous reset mid-GRANT1, then m0 wins the first tie
        m1_valid = 1'b1; m1_addr = 32'h0000_0400;
        tick();
        s_ready = 1'b1;
        #1;
        check("t6_m1_ready_pre", 32'(m1_ready), 32'd1);
        resetn = 1'b0;
        #1;
        check("t6_rst_s_valid",  32'(s_valid),  32'd0);
        check("t6_rst_m1_ready", 32'(m1_ready), 32'd0);
        s_ready  = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0500;
        #1;
        resetn = 1'b1;
        tick();
        check("t6_tie_s_addr", s_addr, 32'h0000_0500);
        check("t6_tie_valid",  32'(s_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
